// File: rtl/cpu_types_pkg.sv
// Shared types and encodings for the fetch unit and control_unit.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    HALT  = 2'd2
  } fetch_state_t;

  // jumpSel encodings, shared with control_unit.
  localparam logic [1:0] JSEL_NPC  = 2'b00;
  localparam logic [1:0] JSEL_JUMP = 2'b01;
  localparam logic [1:0] JSEL_JR   = 2'b10;
  localparam logic [1:0] JSEL_BR   = 2'b11;

  // Sign-extended 16-bit branch offset, scaled to a byte offset.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Instruction-cache port: the fetch unit requests, the icache answers.
interface instruction_fetch_unit_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;

  modport master (output imemREN, imemaddr, input ihit, imemload);
  modport slave  (input imemREN, imemaddr, output ihit, imemload);
endinterface

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection for sequential, jump, jr and branch flow.
module next_pc_calc
  import cpu_types_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  jumpSel,
  input  logic [25:0] imm26,
  input  logic [15:0] imm,
  input  logic [31:0] rs_data,
  input  logic        branch_taken,
  output logic [31:0] npc,
  output logic [31:0] next_pc
);

  assign npc = pc + 32'd4;

  // Select the target; all arithmetic wraps modulo 2^32.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (which would infer a latch).
    next_pc = npc;
    unique case (jumpSel)
      JSEL_NPC:  next_pc = npc;
      JSEL_JUMP: next_pc = {npc[31:28], imm26, 2'b00};
      // Misaligned register targets are silently word-aligned.
      JSEL_JR:   next_pc = rs_data & 32'hFFFF_FFFC;
      JSEL_BR:   next_pc = branch_taken ? npc + branch_offset(imm) : npc;
      default:   next_pc = npc;
    endcase
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetches instruction words from the icache, holds the current one for the
// decoder until the datapath retires it, and registers the next PC.
module instruction_fetch_unit
  import cpu_types_pkg::*;
#(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic                      CLK,
  input  logic                      RST,
  instruction_fetch_unit_if.master  imem,
  output logic [31:0]               instruction,
  output logic                      instr_valid,
  input  logic                      advance,
  input  logic [1:0]                jumpSel,
  input  logic [25:0]               imm26,
  input  logic [15:0]               imm,
  input  logic [31:0]               rs_data,
  input  logic                      branch_taken,
  input  logic                      halt,
  output logic [31:0]               pc,
  output logic [31:0]               npc,
  output logic                      halted
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  next_pc;

  next_pc_calc u_next_pc_calc (
    .pc           (pc_q),
    .jumpSel      (jumpSel),
    .imm26        (imm26),
    .imm          (imm),
    .rs_data      (rs_data),
    .branch_taken (branch_taken),
    .npc          (npc),
    .next_pc      (next_pc)
  );

  // State, PC and held-instruction registers with synchronous reset.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (RST) begin
      state_q <= FETCH;
      pc_q    <= PC_INIT;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  // Next-state and output decode; outputs depend only on registered state.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    imem.imemREN  = 1'b0;
    instr_valid   = 1'b0;
    halted        = 1'b0;
    unique case (state_q)
      FETCH: begin
        imem.imemREN = 1'b1;
        if (imem.ihit) begin
          instr_d = imem.imemload;
          state_d = HOLD;
        end
      end
      HOLD: begin
        instr_valid = 1'b1;
        if (advance) begin
          if (halt) begin
            state_d = HALT;
          end else begin
            pc_d    = next_pc;
            state_d = FETCH;
          end
        end
      end
      HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  assign imem.imemaddr = pc_q;
  assign pc            = pc_q;
  assign instruction   = instr_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed self-checking bench for instruction_fetch_unit (PC_INIT = 0).
module tb_instruction_fetch_unit;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        advance;
  logic [1:0]  jumpSel;
  logic [25:0] imm26;
  logic [15:0] imm;
  logic [31:0] rs_data;
  logic        branch_taken;
  logic        halt;
  logic [31:0] pc;
  logic [31:0] npc;
  logic        halted;

  int checks = 0;
  int passed = 0;

  instruction_fetch_unit_if imem ();

  instruction_fetch_unit #(.PC_INIT(32'h0000_0000)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .imem         (imem),
    .instruction  (instruction),
    .instr_valid  (instr_valid),
    .advance      (advance),
    .jumpSel      (jumpSel),
    .imm26        (imm26),
    .imm          (imm),
    .rs_data      (rs_data),
    .branch_taken (branch_taken),
    .halt         (halt),
    .pc           (pc),
    .npc          (npc),
    .halted       (halted)
  );

  always #5 CLK = ~CLK;

  // One rising edge, then settle 1 time unit before sampling or driving.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One ihit cycle from FETCH; leaves the unit in HOLD.
  task automatic do_fetch(input logic [31:0] word);
    imem.ihit     = 1'b1;
    imem.imemload = word;
    step();
    imem.ihit     = 1'b0;
  endtask

  // One advance cycle from HOLD with the given decoder controls.
  task automatic do_advance(input logic [1:0] js, input logic [25:0] i26,
                            input logic [15:0] i16, input logic [31:0] rs,
                            input logic br, input logic h);
    jumpSel      = js;
    imm26        = i26;
    imm          = i16;
    rs_data      = rs;
    branch_taken = br;
    halt         = h;
    advance      = 1'b1;
    step();
    advance      = 1'b0;
    halt         = 1'b0;
  endtask

  initial begin
    RST = 1'b1; advance = 1'b0; jumpSel = 2'b00; imm26 = '0; imm = '0;
    rs_data = '0; branch_taken = 1'b0; halt = 1'b0;
    imem.ihit = 1'b0; imem.imemload = '0;
    step();
    check("rst_ren", 32'(imem.imemREN), 32'd1);
    check("rst_addr", imem.imemaddr, 32'h0);
    step();
    RST = 1'b0;

    // Reset state.
    check("reset_valid", 32'(instr_valid), 32'd0);
    check("reset_halted", 32'(halted), 32'd0);
    check("reset_npc", npc, 32'h4);
    check("reset_instr", instruction, 32'h0);

    // First fetch: address 0 while fetching, instruction valid next cycle.
    imem.ihit = 1'b1; imem.imemload = 32'h2001_0005;
    check("fetch_addr", imem.imemaddr, 32'h0);
    step();
    imem.ihit = 1'b0;
    check("hold_instr", instruction, 32'h2001_0005);
    check("hold_valid", 32'(instr_valid), 32'd1);
    check("hold_npc", npc, 32'h4);
    check("hold_ren", 32'(imem.imemREN), 32'd0);

    // ihit ignored in HOLD.
    imem.ihit = 1'b1; imem.imemload = 32'hDEAD_BEEF;
    step();
    imem.ihit = 1'b0;
    check("hold_ignores_ihit", instruction, 32'h2001_0005);

    // Sequential advance, then wait on the icache for 3 cycles.
    do_advance(2'b00, '0, '0, '0, 1'b0, 1'b0);
    check("seq_addr", imem.imemaddr, 32'h4);
    for (int i = 0; i < 3; i++) begin
      advance = (i == 1);
      step();
      check("miss_ren", 32'(imem.imemREN), 32'd1);
      check("miss_valid", 32'(instr_valid), 32'd0);
    end
    advance = 1'b0;
    check("fetch_ignores_advance", pc, 32'h4);

    // Jump to 0x40, then taken branch with offset -2 words.
    do_fetch(32'h0800_0010);
    do_advance(2'b01, 26'h10, '0, '0, 1'b0, 1'b0);
    check("jump_0x40", imem.imemaddr, 32'h0000_0040);
    do_fetch(32'h1000_FFFE);
    do_advance(2'b11, '0, 16'hFFFE, '0, 1'b1, 1'b0);
    check("branch_taken", imem.imemaddr, 32'h0000_003C);

    // Back to 0x40, branch not taken.
    do_fetch(32'h0800_0010);
    do_advance(2'b01, 26'h10, '0, '0, 1'b0, 1'b0);
    do_fetch(32'h1000_FFFE);
    check("npc_0x44", npc, 32'h0000_0044);
    do_advance(2'b11, '0, 16'hFFFE, '0, 1'b0, 1'b0);
    check("branch_not_taken", imem.imemaddr, 32'h0000_0044);

    // jr to 0x1000_0000, then j keeps the upper nibble.
    do_fetch(32'h0000_0008);
    do_advance(2'b10, '0, '0, 32'h1000_0000, 1'b0, 1'b0);
    check("jr_0x10000000", imem.imemaddr, 32'h1000_0000);
    do_fetch(32'h0800_0100);
    do_advance(2'b01, 26'h000_0100, '0, '0, 1'b0, 1'b0);
    check("jump_upper_bits", imem.imemaddr, 32'h1000_0400);

    // jr with misaligned target is aligned.
    do_fetch(32'h0000_0008);
    do_advance(2'b10, '0, '0, 32'h0000_0123, 1'b0, 1'b0);
    check("jr_align", imem.imemaddr, 32'h0000_0120);

    // Halt: sticky for 10 cycles with inputs toggling, pc unchanged.
    do_fetch(32'hFFFF_FFFF);
    do_advance(2'b00, '0, '0, '0, 1'b0, 1'b1);
    check("halt_halted", 32'(halted), 32'd1);
    check("halt_ren", 32'(imem.imemREN), 32'd0);
    check("halt_pc", pc, 32'h0000_0120);
    for (int i = 0; i < 10; i++) begin
      imem.ihit = i[0];
      advance   = ~i[0];
      step();
      check("halt_sticky", {29'd0, halted, imem.imemREN, instr_valid}, 32'b100);
    end
    imem.ihit = 1'b0;
    advance   = 1'b0;
    check("halt_pc_held", pc, 32'h0000_0120);

    // Reset leaves HALT and restarts at PC_INIT.
    RST = 1'b1;
    step();
    RST = 1'b0;
    check("rst_from_halt", {29'd0, halted, imem.imemREN, instr_valid}, 32'b010);
    check("rst_from_halt_pc", pc, 32'h0);

    // PC wrap at the top of the address space.
    do_fetch(32'h0000_0008);
    do_advance(2'b10, '0, '0, 32'hFFFF_FFFC, 1'b0, 1'b0);
    check("jr_top", imem.imemaddr, 32'hFFFF_FFFC);
    do_fetch(32'h0000_0000);
    check("npc_wrap", npc, 32'h0);
    do_advance(2'b00, '0, '0, '0, 1'b0, 1'b0);
    check("pc_wrap", imem.imemaddr, 32'h0);

    // Move away from PC_INIT, then reset in the same cycle as ihit.
    do_fetch(32'h0000_0000);
    do_advance(2'b00, '0, '0, '0, 1'b0, 1'b0);
    check("pre_rst_pc", pc, 32'h4);
    RST = 1'b1;
    imem.ihit = 1'b1; imem.imemload = 32'h1234_5678;
    step();
    RST = 1'b0;
    imem.ihit = 1'b0;
    check("rst_ihit_valid", 32'(instr_valid), 32'd0);
    check("rst_ihit_pc", pc, 32'h0);
    check("rst_ihit_instr", instruction, 32'h0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
